// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and sizing constants.
//   PHYS_REG_FILE_IDX_BW : width of a physical register tag
//   REG_FILE_BW          : register data width
//   ROB_DEPTH            : reorder buffer entries (ROB_IDX_BW = clog2)
//   wb_pkt_t             : one write-back result {tag, data, rob index}
package rv32i_pkg;

  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int REG_FILE_BW          = 32;
  localparam int ROB_DEPTH            = 16;
  localparam int ROB_IDX_BW           = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [PHYS_REG_FILE_IDX_BW-1:0] phys_rf_tag;
    logic [REG_FILE_BW-1:0]          wdata;
    logic [ROB_IDX_BW-1:0]           rob_entry_idx;
  } wb_pkt_t;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Per-PU result buffer feeding the write-back arbiter.
//   clk, rstn  : clock, async active-low reset (pointers only)
//   flush      : synchronous empty
//   push       : write push_pkt (caller guarantees !full)
//   pop        : drop head entry (caller guarantees !empty)
//   head_pkt   : current head entry
//   empty/full : derived from registered pointers only
module rv32i_wb_fifo
  import rv32i_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    flush,
  input  logic    push,
  input  wb_pkt_t push_pkt,
  input  logic    pop,
  output wb_pkt_t head_pkt,
  output logic    empty,
  output logic    full
);

  // A depth of 1 still gets a 1-bit index so the pointer slices stay legal;
  // the wrap logic below keeps that index pinned at 0.
  localparam int AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  logic [AW:0] wr_ptr, rd_ptr;
  wb_pkt_t     mem [SLOTS];

  // MSB is the wrap bit; it toggles whenever the index rolls past the last entry.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(BUF_DEPTH-1)) return {~p[AW], {AW{1'b0}}};
    else                               return p + (AW+1)'(1);
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_pkt = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_pkt;
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Write-back bus arbiter: buffers results from NUM_PU processing units and
// broadcasts at most one per cycle, round-robin, on registered outputs.
//   clk, rstn           : clock, async active-low reset
//   i_flush             : drop all buffered results, clear rr pointer
//   i_pu_vld/.._tag/..  : per-PU result handshake and payload
//   o_pu_rdy            : per-PU accept (buffer not full, registered state only)
//   o_write_back, o_phys_rf_wr_idx, o_wdata, o_rob_entry_idx : broadcast
module rv32i_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int NUM_PU    = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        i_flush,
  input  logic [NUM_PU-1:0]                           i_pu_vld,
  input  logic [NUM_PU-1:0][PHYS_REG_FILE_IDX_BW-1:0] i_pu_phys_rf_tag,
  input  logic [NUM_PU-1:0][REG_FILE_BW-1:0]          i_pu_wdata,
  input  logic [NUM_PU-1:0][ROB_IDX_BW-1:0]           i_pu_rob_entry_idx,
  output logic [NUM_PU-1:0]                           o_pu_rdy,
  output logic                                        o_write_back,
  output logic [PHYS_REG_FILE_IDX_BW-1:0]             o_phys_rf_wr_idx,
  output logic [REG_FILE_BW-1:0]                      o_wdata,
  output logic [ROB_IDX_BW-1:0]                       o_rob_entry_idx
);

  localparam int PW = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  logic [NUM_PU-1:0] empty, full, push, pop;
  wb_pkt_t           in_pkt   [NUM_PU];
  wb_pkt_t           head_pkt [NUM_PU];
  logic [PW-1:0]     rr_ptr;
  logic              gnt_vld;
  logic [PW-1:0]     gnt_idx;

  // Ready comes purely from registered occupancy, so a pop from a full
  // buffer only reopens it on the following cycle.
  assign o_pu_rdy = ~full;
  assign push     = i_pu_vld & ~full & {NUM_PU{~i_flush}};

  for (genvar g = 0; g < NUM_PU; g++) begin : g_pu
    assign in_pkt[g] = '{phys_rf_tag:   i_pu_phys_rf_tag[g],
                         wdata:         i_pu_wdata[g],
                         rob_entry_idx: i_pu_rob_entry_idx[g]};

    rv32i_wb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (i_flush),
      .push     (push[g]),
      .push_pkt (in_pkt[g]),
      .pop      (pop[g]),
      .head_pkt (head_pkt[g]),
      .empty    (empty[g]),
      .full     (full[g])
    );
  end

  // Round-robin: first non-empty buffer at or after rr_ptr, wrapping.
  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      c = (int'(rr_ptr) + i) % NUM_PU;
      if (!gnt_vld && !empty[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(c);
      end
    end
    if (i_flush) gnt_vld = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr           <= '0;
      o_write_back     <= 1'b0;
      o_phys_rf_wr_idx <= '0;
      o_wdata          <= '0;
      o_rob_entry_idx  <= '0;
    end else if (i_flush) begin
      rr_ptr       <= '0;
      o_write_back <= 1'b0;
    end else begin
      o_write_back <= gnt_vld;
      // Payload holds its last value on idle cycles.
      if (gnt_vld) begin
        rr_ptr           <= (gnt_idx == PW'(NUM_PU-1)) ? '0 : gnt_idx + PW'(1);
        o_phys_rf_wr_idx <= head_pkt[gnt_idx].phys_rf_tag;
        o_wdata          <= head_pkt[gnt_idx].wdata;
        o_rob_entry_idx  <= head_pkt[gnt_idx].rob_entry_idx;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for rv32i_wb_arbiter (NUM_PU=2, BUF_DEPTH=2).
module tb_rv32i_wb_arbiter;
  import rv32i_pkg::*;

  logic                                   clk, rstn, flush;
  logic [1:0]                             vld;
  logic [1:0][PHYS_REG_FILE_IDX_BW-1:0]   tag;
  logic [1:0][REG_FILE_BW-1:0]            wd;
  logic [1:0][ROB_IDX_BW-1:0]             rob;
  logic [1:0]                             rdy;
  logic                                   wb;
  logic [PHYS_REG_FILE_IDX_BW-1:0]        o_tag;
  logic [REG_FILE_BW-1:0]                 o_wd;
  logic [ROB_IDX_BW-1:0]                  o_rob;

  int checks = 0;
  int errors = 0;

  rv32i_wb_arbiter #(.NUM_PU(2), .BUF_DEPTH(2)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .i_flush            (flush),
    .i_pu_vld           (vld),
    .i_pu_phys_rf_tag   (tag),
    .i_pu_wdata         (wd),
    .i_pu_rob_entry_idx (rob),
    .o_pu_rdy           (rdy),
    .o_write_back       (wb),
    .o_phys_rf_wr_idx   (o_tag),
    .o_wdata            (o_wd),
    .o_rob_entry_idx    (o_rob)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input int k, input logic [5:0] t, input logic [31:0] d, input logic [3:0] r);
    vld[k] = 1'b1; tag[k] = t; wd[k] = d; rob[k] = r;
  endtask

  task automatic do_reset;
    rstn = 0; vld = '0; flush = 0; tag = '0; wd = '0; rob = '0;
    tick; tick;
    rstn = 1;
  endtask

  task automatic test_reset;
    rstn = 0; vld = '0; flush = 0; tag = '0; wd = '0; rob = '0;
    tick; tick;
    checks++; if (wb !== 1'b0)        begin errors++; $display("FAIL reset_wb got %b exp 0", wb); end
    checks++; if (o_tag !== '0)       begin errors++; $display("FAIL reset_tag got %h exp 0", o_tag); end
    checks++; if (o_wd !== '0)        begin errors++; $display("FAIL reset_wdata got %h exp 0", o_wd); end
    checks++; if (o_rob !== '0)       begin errors++; $display("FAIL reset_rob got %h exp 0", o_rob); end
    checks++; if (rdy !== 2'b11)      begin errors++; $display("FAIL reset_rdy got %b exp 11", rdy); end
    rstn = 1;
  endtask

  task automatic test_single;
    do_reset;
    drive(0, 6'd5, 32'h1234, 4'd3);
    tick; // edge 1: accepted
    vld = '0;
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL single_lat got wb=%b exp 0", wb); end
    tick; // edge 2: broadcast
    checks++; if (wb !== 1'b1)  begin errors++; $display("FAIL single_wb got %b exp 1", wb); end
    checks++; if (o_tag !== 6'd5) begin errors++; $display("FAIL single_tag got %h exp 5", o_tag); end
    checks++; if (o_wd !== 32'h1234) begin errors++; $display("FAIL single_wdata got %h exp 1234", o_wd); end
    checks++; if (o_rob !== 4'd3) begin errors++; $display("FAIL single_rob got %h exp 3", o_rob); end
    tick; // edge 3
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", wb); end
    checks++; if (o_wd !== 32'h1234) begin errors++; $display("FAIL single_hold got %h exp 1234", o_wd); end
  endtask

  // Both PUs stream with valid/ready; broadcasts must alternate and each
  // PU's sequence must come out in order with no idle cycle.
  task automatic test_contention;
    int n[2];
    int e[2];
    int p, exp_pu;
    logic [1:0] acc;
    do_reset;
    n[0] = 0; n[1] = 0; e[0] = 0; e[1] = 0; exp_pu = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        vld[k] = 1'b1;
        tag[k] = (k == 1 ? 6'h20 : 6'h10) | 6'(n[k]);
        wd[k]  = 32'hC000_0000 | (k << 16) | n[k];
        rob[k] = 4'(n[k]);
      end
      @(negedge clk) acc = vld & rdy;
      tick;
      for (int k = 0; k < 2; k++) if (acc[k]) n[k]++;
      if (cyc == 0) begin
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL cont_first got wb=%b exp 0", wb); end
      end else begin
        checks++; if (wb !== 1'b1) begin errors++; $display("FAIL cont_rate cyc %0d got wb=%b exp 1", cyc, wb); end
        if (wb === 1'b1) begin
          p = int'(o_tag[5]);
          checks++; if (p != exp_pu) begin errors++; $display("FAIL cont_order cyc %0d got pu %0d exp %0d", cyc, p, exp_pu); end
          checks++; if (o_tag !== ((p == 1 ? 6'h20 : 6'h10) | 6'(e[p])))
            begin errors++; $display("FAIL cont_tag cyc %0d got %h exp seq %0d", cyc, o_tag, e[p]); end
          checks++; if (o_wd !== (32'hC000_0000 | (p << 16) | e[p]))
            begin errors++; $display("FAIL cont_wdata cyc %0d got %h", cyc, o_wd); end
          e[p]++;
          exp_pu ^= 1;
        end
      end
    end
    vld = '0;
    checks++; if (e[0] != 10 || e[1] != 9)
      begin errors++; $display("FAIL cont_count got %0d/%0d exp 10/9", e[0], e[1]); end
    tick; tick; tick; tick; tick; tick; tick; tick;
  endtask

  task automatic test_full;
    do_reset;
    drive(0, 6'h30, 32'h300, 4'd0);
    drive(1, 6'h01, 32'h101, 4'd1);
    tick; // edge1
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL full_e1 got wb=%b exp 0", wb); end
    drive(0, 6'h31, 32'h301, 4'd1);
    drive(1, 6'h02, 32'h102, 4'd2);
    tick; // edge2: PU0 wins, PU1 holds 1,2
    checks++; if (o_tag !== 6'h30) begin errors++; $display("FAIL full_e2_tag got %h exp 30", o_tag); end
    checks++; if (rdy !== 2'b01)   begin errors++; $display("FAIL full_rdy got %b exp 01", rdy); end
    vld[0] = 1'b0;
    drive(1, 6'h03, 32'h103, 4'd3); // must be ignored
    @(negedge clk);
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL full_pop_rdy got %b exp 0", rdy[1]); end
    tick; // edge3: PU1 pops tag 1
    vld = '0;
    checks++; if (o_tag !== 6'h01 || o_wd !== 32'h101) begin errors++; $display("FAIL full_t1 got %h/%h exp 01/101", o_tag, o_wd); end
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL full_rdy_rise got %b exp 1", rdy[1]); end
    tick; // edge4
    checks++; if (o_tag !== 6'h31) begin errors++; $display("FAIL full_e4_tag got %h exp 31", o_tag); end
    tick; // edge5
    checks++; if (wb !== 1'b1 || o_tag !== 6'h02 || o_wd !== 32'h102)
      begin errors++; $display("FAIL full_t2 got wb=%b %h/%h exp 1 02/102", wb, o_tag, o_wd); end
    tick;
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL full_no_t3 got wb=%b tag %h exp 0", wb, o_tag); end
    tick;
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL full_idle got wb=%b exp 0", wb); end
  endtask

  task automatic test_flush;
    do_reset;
    drive(0, 6'h01, 32'hA1, 4'd1);
    drive(1, 6'h02, 32'hA2, 4'd2);
    tick;
    drive(0, 6'h03, 32'hA3, 4'd3);
    drive(1, 6'h04, 32'hA4, 4'd4);
    tick; // 3 buffered, tag 01 out, rr -> PU1
    checks++; if (wb !== 1'b1 || o_tag !== 6'h01) begin errors++; $display("FAIL flush_pre got %b/%h exp 1/01", wb, o_tag); end
    vld = '0;
    flush = 1;
    drive(0, 6'h05, 32'hA5, 4'd5); // dropped by flush
    tick;
    flush = 0; vld = '0;
    checks++; if (wb !== 1'b0)    begin errors++; $display("FAIL flush_wb got %b exp 0", wb); end
    checks++; if (rdy !== 2'b11)  begin errors++; $display("FAIL flush_rdy got %b exp 11", rdy); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (wb !== 1'b0) begin errors++; $display("FAIL flush_quiet %0d got wb=%b tag %h exp 0", i, wb, o_tag); end
    end
    // rr pointer back at 0: PU0 must win a simultaneous pair
    drive(0, 6'h06, 32'hA6, 4'd6);
    drive(1, 6'h07, 32'hA7, 4'd7);
    tick;
    vld = '0;
    tick;
    checks++; if (o_tag !== 6'h06) begin errors++; $display("FAIL flush_rr got %h exp 06", o_tag); end
    tick;
    checks++; if (o_tag !== 6'h07) begin errors++; $display("FAIL flush_rr2 got %h exp 07", o_tag); end
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive(0, 6'h11, 32'hB1, 4'd1);
    drive(1, 6'h12, 32'hB2, 4'd2);
    tick;
    drive(0, 6'h13, 32'hB3, 4'd3);
    tick;
    vld = '0;
    checks++; if (wb !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", wb); end
    #2 rstn = 0;
    #1;
    checks++; if (wb !== 1'b0 || o_tag !== '0 || o_wd !== '0 || o_rob !== '0)
      begin errors++; $display("FAIL rmid_async got %b %h %h %h exp all 0", wb, o_tag, o_wd, o_rob); end
    tick; tick;
    rstn = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (wb !== 1'b0) begin errors++; $display("FAIL rmid_quiet %0d got wb=%b exp 0", i, wb); end
    end
    checks++; if (rdy !== 2'b11) begin errors++; $display("FAIL rmid_rdy got %b exp 11", rdy); end
  endtask

  task automatic test_wrap;
    do_reset;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(0, 6'(i + 1), 32'hA000 + i, 4'(i));
      else        vld = '0;
      tick;
      if (i == 0) begin
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL wrap_first got %b exp 0", wb); end
      end else begin
        checks++; if (wb !== 1'b1 || o_tag !== 6'(i) || o_wd !== 32'hA000 + i - 1 || o_rob !== 4'(i - 1))
          begin errors++; $display("FAIL wrap_%0d got %b %h %h %h", i - 1, wb, o_tag, o_wd, o_rob); end
      end
    end
    tick;
    checks++; if (wb !== 1'b0) begin errors++; $display("FAIL wrap_end got %b exp 0", wb); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_full;
    test_flush;
    test_reset_mid;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

Interface
REQ-001 Parameter NUM_PU, default 2: number of processing units (PUs) feeding the write-back bus, range 1..8.
REQ-002 Parameter BUF_DEPTH, default 2: result buffer entries per PU, power of two, range 1..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous assertion, active-low.
REQ-005 i_flush  input  1  synchronous flush of all buffered results.
REQ-006 i_pu_vld  input  NUM_PU  per-PU result valid.
REQ-007 i_pu_phys_rf_tag  input  NUM_PU x PHYS_REG_FILE_IDX_BW  per-PU destination physical register tag.
REQ-008 i_pu_wdata  input  NUM_PU x REG_FILE_BW  per-PU result data.
REQ-009 i_pu_rob_entry_idx  input  NUM_PU x clog2(ROB_DEPTH)  per-PU reorder buffer (ROB) entry index.
REQ-010 o_pu_rdy  output  NUM_PU  per-PU accept; drives the reservation station's PU-ready input.
REQ-011 o_write_back  output  1  broadcast valid; registered.
REQ-012 o_phys_rf_wr_idx  output  PHYS_REG_FILE_IDX_BW  broadcast tag; registered.
REQ-013 o_wdata  output  REG_FILE_BW  broadcast data; registered.
REQ-014 o_rob_entry_idx  output  clog2(ROB_DEPTH)  ROB entry to mark complete; registered.

Function
REQ-015 Each PU k SHALL own a FIFO of BUF_DEPTH entries holding {tag, data, rob_idx}.
REQ-016 o_pu_rdy[k] SHALL equal "FIFO k not full" and SHALL depend only on the registered occupancy, never on i_pu_vld or on the current cycle's grant.
REQ-017 A result is accepted when i_pu_vld[k] and o_pu_rdy[k] are both high; i_pu_vld[k] while not ready SHALL be ignored, with no state change.
REQ-018 A pop from a full FIFO SHALL NOT raise o_pu_rdy in the same cycle; ready rises the following cycle.
REQ-019 Each cycle, at most one non-empty FIFO SHALL be granted, using a round-robin search starting at rr_ptr and increasing in index with wrap.
REQ-020 After a grant to FIFO g, rr_ptr SHALL become (g+1) mod NUM_PU; with no grant, rr_ptr SHALL hold.
REQ-021 On a grant, the head entry SHALL be popped and registered onto the outputs with o_write_back=1 at the next edge; with no grant, o_write_back SHALL go to 0 and the data outputs SHALL hold.
REQ-022 Latency: a result accepted at edge N into an empty FIFO that wins arbitration SHALL appear with o_write_back=1 in the cycle after edge N+1; there is no bypass path.
REQ-023 A simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL carry one extra wrap bit: full = indices equal with wrap bits differing; empty = indices equal with wrap bits equal.
REQ-025 With i_flush=1, the next edge SHALL: empty all FIFOs, set o_write_back=0, set rr_ptr=0, and perform no grant; a push in the flush cycle SHALL be discarded.
REQ-026 Sustained throughput SHALL be one broadcast per cycle while any FIFO is non-empty.

Reset
REQ-027 While rstn=0, the block SHALL set all FIFO pointers=0, rr_ptr=0, o_write_back=0, and o_phys_rf_wr_idx, o_wdata, o_rob_entry_idx all =0.
REQ-028 Reset assertion mid-transfer SHALL discard all buffered results asynchronously; the first acceptance SHALL occur at the first edge after rstn rises.
REQ-029 FIFO data storage SHALL NOT be reset.

Structure
REQ-030 A wb_pkt_t struct {phys_rf_tag, wdata, rob_entry_idx}, built from the PHYS_REG_FILE_IDX_BW, REG_FILE_BW and ROB_DEPTH constants, SHALL be added to rv32i_pkg.
REQ-031 The per-PU buffer SHALL be a sub-module rv32i_wb_fifo, instantiated NUM_PU times; arbitration and output registers SHALL live in the top module.

Verification
REQ-032 Single result: PU0 sends tag=5, data=0x1234, rob=3 at edge 1 -> o_write_back=1 with 5/0x1234/3 after edge 2, then 0 after edge 3.
REQ-033 Contention: PU0 and PU1 push every cycle, NUM_PU=2 -> broadcasts alternate PU0, PU1, PU0, ...; neither PU starves; one broadcast per cycle.
REQ-034 Full: PU1 pushes tags 1,2 while PU0 continuously wins arbitration, BUF_DEPTH=2 -> o_pu_rdy[1]=0; a third push is ignored; PU1 later broadcasts tags 1,2 in order.
REQ-035 Flush: 3 results buffered, i_flush pulsed one cycle -> no further broadcasts; o_pu_rdy all 1 the next cycle; rr_ptr=0.
REQ-036 Reset mid-operation: rstn dropped with 2 results buffered and o_write_back=1 -> outputs go to 0 immediately without a clock edge; nothing is broadcast after release.
REQ-037 Wrap: 10 sequential pushes and pops on one PU -> all 10 are broadcast in order with correct data across pointer wrap.
